// File: rtl/capture_frame_ctrl.sv
// Frame capture sequencer: arms, waits for vsync, crops an IMG_W x IMG_H window.
// Optional statistics counters are enabled with the CAP_STATS_EN macro.
module capture_frame_ctrl #(
    parameter int IMG_W = 224,
    parameter int IMG_H = 224,
    parameter int CNT_W = 11
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic             cam_pix_en,
    input  logic             arm,
    input  logic [CNT_W-1:0] win_x0,
    input  logic [CNT_W-1:0] win_y0,
    output logic             pix_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
`ifdef CAP_STATS_EN
    output logic [15:0]      frames_ok,
    output logic [15:0]      frames_err,
    output logic [7:0]       arms_dropped,
`endif
    output logic [7:0]       win_col,
    output logic [7:0]       win_row
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_CAPTURE
    } state_t;

    localparam logic [CNT_W:0] W_EXT = (CNT_W+1)'(IMG_W);
    localparam logic [CNT_W:0] H_LST = (CNT_W+1)'(IMG_H - 1);

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic             vsync_q, href_q;
    logic [CNT_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic             pv_q, pv_d, done_q, done_d, err_q, err_d;
    logic [7:0]       wcol_q, wcol_d, wrow_q, wrow_d;
    logic             arm_drop;

    logic             vs_rise, hr_fall, pix_in, hit, last_row;
    logic [CNT_W:0]   col_x, row_x, x_lo, y_lo;
    logic [CNT_W-1:0] dcol, drow;

    assign vs_rise = cam_vsync & ~vsync_q;
    assign hr_fall = href_q & ~cam_href;
    assign pix_in  = cam_pix_en & cam_href;

    // Bounds are one bit wider so x0+IMG_W never overflows
    assign col_x = {1'b0, col_q};
    assign row_x = {1'b0, row_q};
    assign x_lo  = {1'b0, x0_q};
    assign y_lo  = {1'b0, y0_q};
    assign hit   = (col_x >= x_lo) && (col_x < x_lo + W_EXT) &&
                   (row_x >= y_lo) && (row_x < y_lo + W_EXT - W_EXT + H_LST + 1'b1);
    assign last_row = (row_x == y_lo + H_LST);
    assign dcol  = col_q - x0_q;
    assign drow  = row_q - y0_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        col_d     = col_q;
        row_d     = row_q;
        pv_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wcol_d    = wcol_q;
        wrow_d    = wrow_q;
        arm_drop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arm | pending_q) begin
                    state_d   = S_WAIT_VS;
                    pending_d = arm & pending_q;
                end
            end
            S_WAIT_VS: begin
                if (arm) begin
                    if (pending_q) arm_drop  = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (vs_rise) begin
                    state_d = S_CAPTURE;
                    x0_d    = win_x0;
                    y0_d    = win_y0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_CAPTURE: begin
                if (arm) begin
                    if (pending_q) arm_drop  = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (pix_in & hit) begin
                    pv_d   = 1'b1;
                    wcol_d = dcol[7:0];
                    wrow_d = drow[7:0];
                end
                if (hr_fall) begin
                    col_d = '0;
                    if (~&row_q) row_d = row_q + 1'b1;
                end else if (pix_in & ~&col_q) begin
                    col_d = col_q + 1'b1;
                end
                // A new frame start before completion means the window overran
                if (vs_rise) begin
                    state_d   = S_IDLE;
                    err_d     = 1'b1;
                    pending_d = 1'b0;
                end else if (hr_fall & last_row) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            x0_q      <= '0;
            y0_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pv_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wcol_q    <= '0;
            wrow_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            vsync_q   <= cam_vsync;
            href_q    <= cam_href;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pv_q      <= pv_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wcol_q    <= wcol_d;
            wrow_q    <= wrow_d;
        end
    end

    assign pix_valid  = pv_q;
    assign busy       = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign win_col    = wcol_q;
    assign win_row    = wrow_q;

`ifdef CAP_STATS_EN
    logic [15:0] ok_q, bad_q;
    logic [7:0]  drop_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            ok_q   <= '0;
            bad_q  <= '0;
            drop_q <= '0;
        end else begin
            if (done_q & ~&ok_q)     ok_q   <= ok_q + 1'b1;
            if (err_q & ~&bad_q)     bad_q  <= bad_q + 1'b1;
            if (arm_drop & ~&drop_q) drop_q <= drop_q + 1'b1;
        end
    end

    assign frames_ok    = ok_q;
    assign frames_err   = bad_q;
    assign arms_dropped = drop_q;
`else
    logic unused_drop;
    assign unused_drop = arm_drop;
`endif

endmodule

// File: tb/tb_capture_frame_ctrl.sv
// Directed bench for capture_frame_ctrl on a scaled 20x16 sensor, 8x6 window.
module tb_capture_frame_ctrl;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 11;
    localparam int SW = 20;
    localparam int SH = 16;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic          cam_pix_en = 1'b0;
    logic          arm = 1'b0;
    logic [CW-1:0] win_x0 = '0;
    logic [CW-1:0] win_y0 = '0;
    logic          pix_valid, busy, frame_done, frame_err;
    logic [7:0]    win_col, win_row;
`ifdef CAP_STATS_EN
    logic [15:0]   frames_ok, frames_err;
    logic [7:0]    arms_dropped;
`endif

    capture_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_pix_en  (cam_pix_en),
        .arm         (arm),
        .win_x0      (win_x0),
        .win_y0      (win_y0),
        .pix_valid   (pix_valid),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
`ifdef CAP_STATS_EN
        .frames_ok   (frames_ok),
        .frames_err  (frames_err),
        .arms_dropped(arms_dropped),
`endif
        .win_col     (win_col),
        .win_row     (win_row)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Expected pix_valid and coordinates, delayed one pclk like the DUT
    logic       exp_hit = 1'b0;
    logic [7:0] exp_c = '0, exp_r = '0;
    logic       exp_q;
    logic [7:0] exp_cq, exp_rq;

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q  <= 1'b0;
            exp_cq <= '0;
            exp_rq <= '0;
        end else begin
            exp_q  <= exp_hit;
            exp_cq <= exp_c;
            exp_rq <= exp_r;
        end
    end

    int pv_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    int lat_err = 0, crd_err = 0;
    int mark = 0;
    logic [7:0] f_col = '0, f_row = '0, l_col = '0, l_row = '0;

    always @(negedge pclk) begin
        if (rst_n) begin
            if (pix_valid !== exp_q) lat_err++;
            if (pix_valid) begin
                if (pv_cnt == mark) begin
                    f_col = win_col;
                    f_row = win_row;
                end
                l_col = win_col;
                l_row = win_row;
                if (win_col !== exp_cq || win_row !== exp_rq) crd_err++;
                pv_cnt++;
            end
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
            if (busy)       busy_cnt++;
        end
    end

    int b_pv, b_done, b_err, b_busy, b_lat, b_crd;

    task automatic snap();
        b_pv   = pv_cnt;
        b_done = done_cnt;
        b_err  = err_cnt;
        b_busy = busy_cnt;
        b_lat  = lat_err;
        b_crd  = crd_err;
        mark   = pv_cnt;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        repeat (2) tick();
        cam_vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic frame(input int div, input bit cap_in, input int rst_y);
        bit cap;
        bit in_win;
        cap = cap_in;
        vsync_pulse();
        for (int y = 0; y < SH; y++) begin
            cam_href = 1'b1;
            for (int x = 0; x < SW; x++) begin
                if (y == rst_y && x == 10) begin
                    check("mid_busy", 32'(busy), 1);
                    rst_n = 1'b0;
                    #1;
                    check("rst_zero", {16'h0, pix_valid, busy, frame_done,
                                       frame_err, win_col, win_row[3:0]}, 0);
                    check("rst_row", 32'(win_row), 0);
                    cap = 1'b0;
                    tick();
                    rst_n = 1'b1;
                end
                in_win = (x >= int'(win_x0)) && (x < int'(win_x0) + W) &&
                         (y >= int'(win_y0)) && (y < int'(win_y0) + H);
                cam_pix_en = 1'b1;
                exp_hit    = cap && in_win;
                exp_c      = 8'(x - int'(win_x0));
                exp_r      = 8'(y - int'(win_y0));
                tick();
                cam_pix_en = 1'b0;
                exp_hit    = 1'b0;
                repeat (div - 1) tick();
            end
            cam_href = 1'b0;
            repeat (3) tick();
        end
        repeat (2) tick();
    endtask

    task automatic check_frame(input string t, input int pv, input int dn,
                               input int er);
        check({t, "_pv"},   32'(pv_cnt - b_pv), 32'(pv));
        check({t, "_done"}, 32'(done_cnt - b_done), 32'(dn));
        check({t, "_err"},  32'(err_cnt - b_err), 32'(er));
        check({t, "_lat"},  32'(lat_err - b_lat), 0);
        check({t, "_crd"},  32'(crd_err - b_crd), 0);
        check({t, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        repeat (3) tick();
        check("reset_out", {16'h0, pix_valid, busy, frame_done, frame_err,
                            win_col, win_row[3:0]}, 0);
        check("reset_row", 32'(win_row), 0);
        rst_n = 1'b1;
        tick();

        // Single capture, interior window
        win_x0 = 11'd5;
        win_y0 = 11'd3;
        snap();
        pulse_arm();
        check("t1_busy_arm", 32'(busy), 1);
        frame(1, 1'b1, -1);
        check_frame("t1", W * H, 1, 0);
        check("t1_first", {16'h0, f_col, f_row}, 32'h0000);
        check("t1_last",  {16'h0, l_col, l_row}, 32'h0705);
        check("t1_hold",  {16'h0, win_col, win_row}, 32'h0705);

        // No arm: nothing happens across three frames
        snap();
        repeat (3) frame(1, 1'b0, -1);
        check("t2_pv",   32'(pv_cnt - b_pv), 0);
        check("t2_busy", 32'(busy_cnt - b_busy), 0);

        // Window runs past the last sensor line
        win_x0 = 11'd0;
        win_y0 = 11'd12;
        snap();
        pulse_arm();
        frame(1, 1'b1, -1);
        check("t3_no_err_yet", 32'(err_cnt - b_err), 0);
        vsync_pulse();
        repeat (2) tick();
        check_frame("t3", W * 4, 0, 1);

        // Arm during capture queues a back-to-back capture
        win_x0 = 11'd0;
        win_y0 = 11'd0;
        snap();
        pulse_arm();
        fork
            frame(1, 1'b1, -1);
            begin
                repeat (50) tick();
                pulse_arm();
            end
        join
        check("t4a_busy_pend", 32'(busy), 1);
        frame(1, 1'b1, -1);
        check_frame("t4a", 2 * W * H, 2, 0);
`ifdef CAP_STATS_EN
        check("t4a_ok",   32'(frames_ok), 3);
        check("t4a_ferr", 32'(frames_err), 1);
        check("t4a_drop", 32'(arms_dropped), 0);
`endif

        // Second arm while pending is dropped
        snap();
        pulse_arm();
        fork
            frame(1, 1'b1, -1);
            begin
                repeat (50) tick();
                pulse_arm();
                tick();
                pulse_arm();
            end
        join
        frame(1, 1'b1, -1);
        repeat (2) frame(1, 1'b0, -1);
        check_frame("t4b", 2 * W * H, 2, 0);
`ifdef CAP_STATS_EN
        check("t4b_ok",   32'(frames_ok), 5);
        check("t4b_drop", 32'(arms_dropped), 1);
`endif

        // Window in the bottom-right corner, slow pixel strobe
        win_x0 = 11'd12;
        win_y0 = 11'd10;
        snap();
        pulse_arm();
        frame(2, 1'b1, -1);
        check_frame("t6", W * H, 1, 0);
        check("t6_last", {16'h0, l_col, l_row}, 32'h0705);

        // Asynchronous reset in the middle of a capture
        win_x0 = 11'd5;
        win_y0 = 11'd3;
        pulse_arm();
        frame(1, 1'b1, 4);
        snap();
        check("t5_after_rst", {16'h0, pix_valid, busy, win_col, win_row[6:0]}, 0);
        pulse_arm();
        frame(1, 1'b1, -1);
        check_frame("t5", W * H, 1, 0);
        check("t5_first", {16'h0, f_col, f_row}, 32'h0000);
        check("t5_last",  {16'h0, l_col, l_row}, 32'h0705);
`ifdef CAP_STATS_EN
        check("t5_ok",   32'(frames_ok), 1);
        check("t5_ferr", 32'(frames_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
